// File: rtl/sd_sector_responder.sv
// ----------------------------------------------------------------------------
// sd_sector_responder
//   Target side of the sd_lba / sd_rd / sd_wr / sd_ack sector protocol. It
//   serves one 512-byte sector (256 x 16-bit words) per request. The sector
//   data lives in a word-addressed backing store that uses a toggle req/ack
//   handshake. This lets backup-RAM save/load run entirely in-core, as a
//   RAM disk.
//
// Ports
//   clk_sys       system clock
//   reset         asynchronous, active-high reset
//   sd_lba        sector number, sampled when a request is accepted
//   sd_rd/sd_wr   level requests (read: sector -> initiator, write: reverse)
//   sd_ack        high for the whole transfer of one sector
//   sd_buff_addr  word index within the sector (initiator buffer address)
//   sd_buff_dout  read data towards the initiator buffer
//   sd_buff_din   write data from the initiator buffer (BUF_LAT cycles late)
//   sd_buff_wr    one-cycle strobe: write sd_buff_dout at sd_buff_addr
//   mem_addr      store word address {lba[LBA_W-1:0], word index}
//   mem_wdata     store write data
//   mem_rdata     store read data, valid once mem_rd_ack == mem_rd_req
//   mem_rd_req/ack, mem_wr_req/ack   toggle handshakes to the store
//   lba_err       sticky: some request addressed a sector beyond the store
// ----------------------------------------------------------------------------
module sd_sector_responder #(
    parameter int LBA_W   = 7,
    parameter int BUF_LAT = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [31:0]        sd_lba,
    input  logic               sd_rd,
    input  logic               sd_wr,
    output logic               sd_ack,
    output logic [7:0]         sd_buff_addr,
    output logic [15:0]        sd_buff_dout,
    input  logic [15:0]        sd_buff_din,
    output logic               sd_buff_wr,
    output logic [LBA_W+7:0]   mem_addr,
    output logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata,
    output logic               mem_rd_req,
    input  logic               mem_rd_ack,
    output logic               mem_wr_req,
    input  logic               mem_wr_ack,
    output logic               lba_err
);

    localparam int LAT_W = (BUF_LAT > 1) ? $clog2(BUF_LAT) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_LAT, WR_REQ, WR_WAIT, DONE
    } state_t;

    state_t             state;
    logic [LBA_W-1:0]   lba_q;
    logic               oor;       // current request is beyond the store
    logic [7:0]         idx;
    logic [LAT_W-1:0]   lat_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lba_q        <= '0;
            oor          <= 1'b0;
            idx          <= '0;
            lat_cnt      <= '0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;
            lba_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sd_rd || sd_wr) begin
                        lba_q   <= sd_lba[LBA_W-1:0];
                        oor     <= |sd_lba[31:LBA_W];
                        lba_err <= lba_err | (|sd_lba[31:LBA_W]);
                        idx     <= '0;
                        sd_ack  <= 1'b1;
                        // Read wins when both requests are raised together.
                        state   <= sd_rd ? RD_REQ : WR_ADDR;
                    end
                end

                RD_REQ: begin
                    mem_addr <= {lba_q, idx};
                    // Out-of-range sectors never reach the store; the
                    // handshake then stays balanced and RD_WAIT falls through.
                    if (!oor) mem_rd_req <= ~mem_rd_req;
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (mem_rd_ack == mem_rd_req) begin
                        sd_buff_addr <= idx;
                        sd_buff_dout <= oor ? 16'h0000 : mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end
                end

                RD_PUT: begin
                    sd_buff_wr <= 1'b0;
                    if (idx == 8'hFF) begin
                        idx    <= '0;
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= RD_REQ;
                    end
                end

                WR_ADDR: begin
                    sd_buff_addr <= idx;
                    lat_cnt      <= '0;
                    state        <= WR_LAT;
                end

                // The initiator's buffer is registered; give its output time
                // to follow the new address before sampling sd_buff_din.
                WR_LAT: begin
                    if (int'(lat_cnt) + 1 >= BUF_LAT) state <= WR_REQ;
                    else                              lat_cnt <= lat_cnt + 1'b1;
                end

                WR_REQ: begin
                    mem_addr  <= {lba_q, idx};
                    mem_wdata <= sd_buff_din;
                    if (!oor) mem_wr_req <= ~mem_wr_req;
                    state <= WR_WAIT;
                end

                WR_WAIT: begin
                    if (mem_wr_ack == mem_wr_req) begin
                        if (idx == 8'hFF) begin
                            idx    <= '0;
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= WR_ADDR;
                        end
                    end
                end

                // One idle cycle guarantees the initiator's re-request, raised
                // on the sd_ack falling edge, is seen as a fresh request.
                DONE: begin
                    sd_buff_wr <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_responder.sv
module tb_sd_sector_responder;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] sd_lba  = '0;
    logic        sd_rd   = 1'b0;
    logic        sd_wr   = 1'b0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic [15:0] sd_buff_din;
    logic        sd_buff_wr;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic        mem_wr_req;
    logic        mem_wr_ack;
    logic        lba_err;

    sd_sector_responder #(.LBA_W(7), .BUF_LAT(2)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_ack   (mem_rd_ack),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_ack   (mem_wr_ack),
        .lba_err      (lba_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Backing store model, expected-content model, and initiator buffers.
    logic [15:0] store_mem [0:32767];
    logic [15:0] model     [0:32767];
    logic [15:0] wbuf      [0:255];
    logic [15:0] rbuf      [0:255];
    logic        preload   = 1'b0;
    logic        stall_en  = 1'b0;
    logic [4:0]  stall     = '0;
    int          wr_count  = 0;
    int          strobe_cnt = 0;
    int          order_err  = 0;
    int          noack_strobe = 0;
    logic [15:0] buf_s1;

    function automatic logic [15:0] init_word(input int a);
        return 16'((a * 40503) ^ 16'h1357);
    endfunction

    // Toggle-handshake store with optional random stall per access.
    always @(posedge clk_sys) begin
        if (preload) begin
            for (int a = 0; a < 32768; a++) store_mem[a] <= init_word(a);
        end
        if (reset) begin
            mem_rd_ack <= 1'b0;
            mem_wr_ack <= 1'b0;
            stall      <= '0;
        end else if (stall != 0 && (mem_rd_req != mem_rd_ack || mem_wr_req != mem_wr_ack)) begin
            stall <= stall - 5'd1;
        end else begin
            if (mem_rd_req != mem_rd_ack) begin
                mem_rdata  <= store_mem[mem_addr];
                mem_rd_ack <= mem_rd_req;
                stall      <= stall_en ? 5'($urandom_range(0, 20)) : 5'd0;
            end
            if (mem_wr_req != mem_wr_ack) begin
                store_mem[mem_addr] <= mem_wdata;
                mem_wr_ack <= mem_wr_req;
                wr_count   <= wr_count + 1;
                stall      <= stall_en ? 5'($urandom_range(0, 20)) : 5'd0;
            end
        end
    end

    // Initiator buffer: registered BRAM with two cycles of read latency.
    always @(posedge clk_sys) begin
        buf_s1      <= wbuf[sd_buff_addr];
        sd_buff_din <= buf_s1;
    end

    // Initiator receive side: capture strobes, track order and ack coverage.
    always @(posedge clk_sys) begin
        if (sd_buff_wr === 1'b1) begin
            rbuf[sd_buff_addr] <= sd_buff_dout;
            if (sd_buff_addr !== strobe_cnt[7:0]) order_err <= order_err + 1;
            if (sd_ack !== 1'b1) noack_strobe <= noack_strobe + 1;
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    function automatic int rbuf_bad(input int lba, input bit expect_zero);
        int n = 0;
        for (int i = 0; i < 256; i++) begin
            if (expect_zero) begin
                if (rbuf[i] !== 16'h0000) n++;
            end else if (rbuf[i] !== model[lba * 256 + i]) n++;
        end
        return n;
    endfunction

    // Issue one request like the initiator does and wait for its completion.
    task automatic do_req(input logic rd, input logic wr, input int lba, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk_sys);
        sd_lba = 32'(lba);
        sd_rd  = rd;
        sd_wr  = wr;
        n = 0;
        while (sd_ack !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        if (sd_ack !== 1'b1) ok = 1'b0;
        n = 0;
        while (sd_ack !== 1'b0 && n < 10000) begin @(negedge clk_sys); n++; end
        if (sd_ack !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        preload = 1'b1;
        for (int a = 0; a < 32768; a++) model[a] = init_word(a);
        repeat (2) @(negedge clk_sys);
        preload = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL reset_sd_ack: got %b want 0", sd_ack); end
        checks++; if (sd_buff_wr !== 1'b0) begin errors++; $display("FAIL reset_buff_wr: got %b want 0", sd_buff_wr); end
        checks++; if (sd_buff_addr !== 8'h00) begin errors++; $display("FAIL reset_buff_addr: got %h want 00", sd_buff_addr); end
        checks++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin errors++; $display("FAIL reset_reqs: got rd=%b wr=%b want 0/0", mem_rd_req, mem_wr_req); end
        checks++; if (lba_err !== 1'b0) begin errors++; $display("FAIL reset_lba_err: got %b want 0", lba_err); end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL idle_sd_ack: got %b want 0", sd_ack); end
    endtask

    task automatic test_write_sector();
        bit ok;
        int w0, bad;
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(i) ^ 16'hA5A5;
        w0 = wr_count;
        do_req(1'b0, 1'b1, 5, ok);
        for (int i = 0; i < 256; i++) model[5 * 256 + i] = 16'(i) ^ 16'hA5A5;
        checks++; if (!ok) begin errors++; $display("FAIL wr5_handshake: got incomplete want complete"); end
        checks++; if (wr_count - w0 != 256) begin errors++; $display("FAIL wr5_count: got %0d want 256", wr_count - w0); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (store_mem[16'h500 + i] !== (16'(i) ^ 16'hA5A5)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wr5_store: got %0d bad words want 0", bad); end
        checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL wr5_ack_low: got %b want 0", sd_ack); end
    endtask

    task automatic test_read_sector();
        bit ok;
        int s0, o0, n0, bad;
        s0 = strobe_cnt; o0 = order_err; n0 = noack_strobe;
        do_req(1'b1, 1'b0, 5, ok);
        @(negedge clk_sys);
        checks++; if (!ok) begin errors++; $display("FAIL rd5_handshake: got incomplete want complete"); end
        checks++; if (strobe_cnt - s0 != 256) begin errors++; $display("FAIL rd5_strobes: got %0d want 256", strobe_cnt - s0); end
        checks++; if (order_err != o0) begin errors++; $display("FAIL rd5_order: got %0d out-of-order want 0", order_err - o0); end
        checks++; if (noack_strobe != n0) begin errors++; $display("FAIL rd5_noack: got %0d strobes without ack want 0", noack_strobe - n0); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (rbuf[i] !== (16'(i) ^ 16'hA5A5)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rd5_data: got %0d bad words want 0", bad); end
    endtask

    task automatic test_multi_sector();
        int lbas [8] = '{0, 1, 2, 3, 64, 125, 126, 127};
        bit ok;
        int s0, o0, bad_sect;
        stall_en = 1'b1;
        bad_sect = 0;
        s0 = strobe_cnt; o0 = order_err;
        for (int k = 0; k < 8; k++) begin
            do_req(1'b1, 1'b0, lbas[k], ok);
            @(negedge clk_sys);
            if (!ok || rbuf_bad(lbas[k], 1'b0) != 0) bad_sect++;
        end
        stall_en = 1'b0;
        checks++; if (bad_sect != 0) begin errors++; $display("FAIL multi_data: got %0d bad sectors want 0", bad_sect); end
        checks++; if (strobe_cnt - s0 != 8 * 256) begin errors++; $display("FAIL multi_strobes: got %0d want %0d", strobe_cnt - s0, 8 * 256); end
        checks++; if (order_err != o0) begin errors++; $display("FAIL multi_order: got %0d want 0", order_err - o0); end
        checks++; if (lba_err !== 1'b0) begin errors++; $display("FAIL multi_lba_err: got %b want 0", lba_err); end
    endtask

    task automatic test_lba_range();
        bit ok;
        int s0, w0, bad;
        s0 = strobe_cnt; w0 = wr_count;
        do_req(1'b1, 1'b0, 128, ok);
        @(negedge clk_sys);
        checks++; if (lba_err !== 1'b1) begin errors++; $display("FAIL oor_lba_err: got %b want 1", lba_err); end
        checks++; if (strobe_cnt - s0 != 256) begin errors++; $display("FAIL oor_strobes: got %0d want 256", strobe_cnt - s0); end
        bad = rbuf_bad(0, 1'b1);
        checks++; if (bad != 0) begin errors++; $display("FAIL oor_zero_data: got %0d nonzero words want 0", bad); end
        checks++; if (wr_count != w0) begin errors++; $display("FAIL oor_store_writes: got %0d want 0", wr_count - w0); end
        do_req(1'b1, 1'b0, 5, ok);
        @(negedge clk_sys);
        bad = rbuf_bad(5, 1'b0);
        checks++; if (!ok || bad != 0) begin errors++; $display("FAIL after_oor_read: got ok=%0d bad=%0d want ok=1 bad=0", ok, bad); end
        checks++; if (lba_err !== 1'b1) begin errors++; $display("FAIL lba_err_sticky: got %b want 1", lba_err); end
    endtask

    task automatic test_rd_wr_priority();
        bit ok;
        int s0, w0, bad;
        for (int i = 0; i < 256; i++) wbuf[i] = 16'hDEAD;
        s0 = strobe_cnt; w0 = wr_count;
        do_req(1'b1, 1'b1, 3, ok);
        @(negedge clk_sys);
        checks++; if (strobe_cnt - s0 != 256) begin errors++; $display("FAIL both_strobes: got %0d want 256", strobe_cnt - s0); end
        checks++; if (wr_count != w0) begin errors++; $display("FAIL both_no_write: got %0d writes want 0", wr_count - w0); end
        bad = rbuf_bad(3, 1'b0);
        checks++; if (!ok || bad != 0) begin errors++; $display("FAIL both_data: got ok=%0d bad=%0d want ok=1 bad=0", ok, bad); end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        int n, w0, bad;
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(i * 257 + 7);
        w0 = wr_count;
        @(negedge clk_sys);
        sd_lba = 32'd9;
        sd_wr  = 1'b1;
        n = 0;
        while (sd_ack !== 1'b1 && n < 50) begin @(negedge clk_sys); n++; end
        sd_wr = 1'b0;
        n = 0;
        while (wr_count - w0 < 100 && n < 5000) begin @(negedge clk_sys); n++; end
        checks++; if (wr_count - w0 != 100) begin errors++; $display("FAIL mid_write_progress: got %0d words want 100", wr_count - w0); end
        reset = 1'b1;
        #1;
        checks++; if (sd_ack !== 1'b0 || sd_buff_wr !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got ack=%b wr=%b want 0/0", sd_ack, sd_buff_wr); end
        checks++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin errors++; $display("FAIL mid_reset_reqs: got rd=%b wr=%b want 0/0", mem_rd_req, mem_wr_req); end
        checks++; if (lba_err !== 1'b0) begin errors++; $display("FAIL mid_reset_lba_err: got %b want 0", lba_err); end
        for (int i = 0; i < 100; i++) model[9 * 256 + i] = 16'(i * 257 + 7);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        do_req(1'b1, 1'b0, 9, ok);
        @(negedge clk_sys);
        bad = rbuf_bad(9, 1'b0);
        checks++; if (!ok || bad != 0) begin errors++; $display("FAIL mid_reset_readback: got ok=%0d bad=%0d want ok=1 bad=0", ok, bad); end
        checks++; if (rbuf[99] !== 16'(99 * 257 + 7) || rbuf[100] !== init_word(9 * 256 + 100)) begin
            errors++; $display("FAIL mid_reset_boundary: got %h/%h want %h/%h", rbuf[99], rbuf[100], 16'(99 * 257 + 7), init_word(9 * 256 + 100));
        end
    endtask

    initial begin
        test_reset();
        test_write_sector();
        test_read_sector();
        test_multi_sector();
        test_lba_range();
        test_rd_wr_priority();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
